// File: rtl/sram_arbiter_if.sv
// Bus bundle between the two datapath masters, the sram_arbiter and the
// SRAM macro wrapper.
//   slave  : the arbiter's view (master requests in, grants/read data out,
//            SRAM strobes out, SRAM read data in)
//   master : the opposite view, used by whatever drives the masters and
//            models the SRAM
// Master 0 / master 1 request fields: i_req, i_we, i_addr, i_wdata.
// Per-master responses: o_gnt (combinational accept), o_rvalid (read pulse).
// Shared read data: o_rdata. SRAM side: o_sram_addr/data/wen/oen, i_sram_data.
interface sram_arbiter_if #(
  parameter int BW_DATA = 64,
  parameter int BW_ADDR = 6
);
  logic               i_req0;
  logic               i_we0;
  logic [BW_ADDR-1:0] i_addr0;
  logic [BW_DATA-1:0] i_wdata0;
  logic               o_gnt0;
  logic               o_rvalid0;

  logic               i_req1;
  logic               i_we1;
  logic [BW_ADDR-1:0] i_addr1;
  logic [BW_DATA-1:0] i_wdata1;
  logic               o_gnt1;
  logic               o_rvalid1;

  logic [BW_DATA-1:0] o_rdata;

  logic [BW_ADDR-1:0] o_sram_addr;
  logic [BW_DATA-1:0] o_sram_data;
  logic               o_sram_wen;
  logic               o_sram_oen;
  logic [BW_DATA-1:0] i_sram_data;

  modport slave (
    input  i_req0, i_we0, i_addr0, i_wdata0,
    input  i_req1, i_we1, i_addr1, i_wdata1,
    output o_gnt0, o_rvalid0, o_gnt1, o_rvalid1, o_rdata,
    output o_sram_addr, o_sram_data, o_sram_wen, o_sram_oen,
    input  i_sram_data
  );

  modport master (
    output i_req0, i_we0, i_addr0, i_wdata0,
    output i_req1, i_we1, i_addr1, i_wdata1,
    input  o_gnt0, o_rvalid0, o_gnt1, o_rvalid1, o_rdata,
    input  o_sram_addr, o_sram_data, o_sram_wen, o_sram_oen,
    output i_sram_data
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-master round-robin arbiter and access sequencer for the banked SRAM.
// One SRAM access is issued per cycle in grant order; read data comes back
// to the requesting master a fixed RD_LAT+2 cycles after its grant.
// Ports:
//   i_clk : rising-edge clock
//   i_rst : synchronous active-high reset
//   bus   : sram_arbiter_if.slave (master requests/responses + SRAM strobes)
// Parameters:
//   BW_DATA : data width (SRAM word width)
//   BW_ADDR : word address width
//   RD_LAT  : SRAM read latency from oen to valid i_sram_data, 1..4
module sram_arbiter #(
  parameter int BW_DATA = 64,
  parameter int BW_ADDR = 6,
  parameter int RD_LAT  = 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  sram_arbiter_if.slave bus
);

  typedef enum logic {
    PRI_M0 = 1'b0,
    PRI_M1 = 1'b1
  } pri_e;

  pri_e               pri_q, pri_d;
  logic               gnt0, gnt1;

  logic               sel_we;
  logic [BW_ADDR-1:0] sel_addr;
  logic [BW_DATA-1:0] sel_wdata;

  logic               sram_wen_q, sram_oen_q;
  logic [BW_ADDR-1:0] sram_addr_q;
  logic [BW_DATA-1:0] sram_data_q;
  logic               issue_id_q;    // master that owns the access on the SRAM pins

  logic [RD_LAT-1:0]  tag_valid_q;
  logic [RD_LAT-1:0]  tag_id_q;

  logic               rvalid0_q, rvalid1_q;
  logic [BW_DATA-1:0] rdata_q;

  // Arbitration and priority-pointer update.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the ifs can leave a value unassigned and infer a latch.
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    pri_d = pri_q;
    if (!i_rst) begin
      if (bus.i_req0 && (!bus.i_req1 || pri_q == PRI_M0)) begin
        gnt0 = 1'b1;
      end else if (bus.i_req1) begin
        gnt1 = 1'b1;
      end
    end
    // Pointer moves to the loser after every grant, holds otherwise.
    if (gnt0) begin
      pri_d = PRI_M1;
    end else if (gnt1) begin
      pri_d = PRI_M0;
    end
  end

  assign sel_we    = gnt1 ? bus.i_we1    : bus.i_we0;
  assign sel_addr  = gnt1 ? bus.i_addr1  : bus.i_addr0;
  assign sel_wdata = gnt1 ? bus.i_wdata1 : bus.i_wdata0;

  // Priority pointer and issue stage.
  always_ff @(posedge i_clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (i_rst) begin
      pri_q       <= PRI_M0;
      sram_wen_q  <= 1'b0;
      sram_oen_q  <= 1'b0;
      sram_addr_q <= '0;
      sram_data_q <= '0;
      issue_id_q  <= 1'b0;
    end else begin
      pri_q <= pri_d;
      if (gnt0 || gnt1) begin
        sram_wen_q  <= sel_we;
        sram_oen_q  <= ~sel_we;
        sram_addr_q <= sel_addr;
        sram_data_q <= sel_wdata;
        issue_id_q  <= gnt1;
      end else begin
        // Idle cycle: strobes drop, address and data bus hold.
        sram_wen_q <= 1'b0;
        sram_oen_q <= 1'b0;
      end
    end
  end

  // Read tag pipeline: stage 0 lines up with the cycle after oen, the last
  // stage with the cycle in which i_sram_data is valid.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tag_valid_q <= '0;
    end else begin
      tag_valid_q[0] <= sram_oen_q;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_valid_q[i] <= tag_valid_q[i-1];
      end
    end
  end

  // NOTE: the master-id payload is only meaningful alongside its valid bit,
  // so it carries no reset; only the valid bits are cleared.
  always_ff @(posedge i_clk) begin
    tag_id_q[0] <= issue_id_q;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_id_q[i] <= tag_id_q[i-1];
    end
  end

  // Read return: capture SRAM data as the tag emerges and steer the pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      rvalid0_q <= tag_valid_q[RD_LAT-1] & ~tag_id_q[RD_LAT-1];
      rvalid1_q <= tag_valid_q[RD_LAT-1] &  tag_id_q[RD_LAT-1];
      if (tag_valid_q[RD_LAT-1]) begin
        rdata_q <= bus.i_sram_data;
      end
    end
  end

  assign bus.o_gnt0      = gnt0;
  assign bus.o_gnt1      = gnt1;
  assign bus.o_rvalid0   = rvalid0_q;
  assign bus.o_rvalid1   = rvalid1_q;
  assign bus.o_rdata     = rdata_q;
  assign bus.o_sram_addr = sram_addr_q;
  assign bus.o_sram_data = sram_data_q;
  assign bus.o_sram_wen  = sram_wen_q;
  assign bus.o_sram_oen  = sram_oen_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: one instance with RD_LAT=1 and one with
// RD_LAT=3, both in front of a shared behavioural 64x64 memory that is
// preloaded with mem[i] = i.
module tb_sram_arbiter;
  localparam int BW_DATA = 64;
  localparam int BW_ADDR = 6;
  localparam logic [63:0] BAD  = 64'hBADD_BADD_BADD_BADD;
  localparam logic [63:0] BEEF = 64'hDEAD_BEEF_0123_4567;

  logic clk = 1'b0;
  logic rst;
  logic mem_init;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sram_arbiter_if #(.BW_DATA(BW_DATA), .BW_ADDR(BW_ADDR)) ba ();
  sram_arbiter_if #(.BW_DATA(BW_DATA), .BW_ADDR(BW_ADDR)) bb ();

  sram_arbiter #(.BW_DATA(BW_DATA), .BW_ADDR(BW_ADDR), .RD_LAT(1)) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (ba.slave)
  );

  sram_arbiter #(.BW_DATA(BW_DATA), .BW_ADDR(BW_ADDR), .RD_LAT(3)) u_dut3 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bb.slave)
  );

  // Shared memory; only the RD_LAT=1 instance writes.
  logic [63:0] mem [64];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 64'(i);
    end else if (ba.o_sram_wen) begin
      mem[ba.o_sram_addr] <= ba.o_sram_data;
    end
  end

  // 1-cycle read port; garbage outside the valid cycle exposes timing slips.
  always @(posedge clk) begin
    ba.i_sram_data <= ba.o_sram_oen ? mem[ba.o_sram_addr] : BAD;
  end

  // 3-cycle read port.
  logic [63:0] pipe3 [3];
  logic [2:0]  vld3 = '0;
  always @(posedge clk) begin
    pipe3[0] <= mem[bb.o_sram_addr];
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
    vld3     <= {vld3[1:0], bb.o_sram_oen};
  end
  assign bb.i_sram_data = vld3[2] ? pipe3[2] : BAD;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_data(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic req, input logic we, input logic [5:0] addr, input logic [63:0] wd);
    ba.i_req0   = req;
    ba.i_we0    = we;
    ba.i_addr0  = addr;
    ba.i_wdata0 = wd;
  endtask

  task automatic drive1(input logic req, input logic we, input logic [5:0] addr, input logic [63:0] wd);
    ba.i_req1   = req;
    ba.i_we1    = we;
    ba.i_addr1  = addr;
    ba.i_wdata1 = wd;
  endtask

  initial begin
    int i0;
    int i1;
    int d;

    // ---- reset with both masters requesting ----
    rst      = 1'b1;
    mem_init = 1'b1;
    drive0(1'b1, 1'b0, 6'd0, 64'd0);
    drive1(1'b1, 1'b0, 6'd0, 64'd0);
    bb.i_req0 = 1'b0; bb.i_we0 = 1'b0; bb.i_addr0 = '0; bb.i_wdata0 = '0;
    bb.i_req1 = 1'b0; bb.i_we1 = 1'b0; bb.i_addr1 = '0; bb.i_wdata1 = '0;
    step();
    check("rst_gnt0_c1", ba.o_gnt0, 1'b0);
    check("rst_gnt1_c1", ba.o_gnt1, 1'b0);
    step();
    check("rst_gnt0", ba.o_gnt0, 1'b0);
    check("rst_gnt1", ba.o_gnt1, 1'b0);
    check("rst_wen", ba.o_sram_wen, 1'b0);
    check("rst_oen", ba.o_sram_oen, 1'b0);
    check("rst_rvalid0", ba.o_rvalid0, 1'b0);
    check("rst_rvalid1", ba.o_rvalid1, 1'b0);
    check_data("rst_addr", 64'(ba.o_sram_addr), 64'd0);
    check_data("rst_sdata", ba.o_sram_data, 64'd0);
    check_data("rst_rdata", ba.o_rdata, 64'd0);
    check("rst_oen_lat3", bb.o_sram_oen, 1'b0);

    // Release: master 0 wins the first cycle.
    rst      = 1'b0;
    mem_init = 1'b0;
    #1;
    check("rel_gnt0", ba.o_gnt0, 1'b1);
    check("rel_gnt1", ba.o_gnt1, 1'b0);
    step();
    drive0(1'b0, 1'b0, 6'd0, 64'd0);
    drive1(1'b0, 1'b0, 6'd0, 64'd0);
    check("rel_oen", ba.o_sram_oen, 1'b1);
    step();
    step();
    check("rel_rvalid0", ba.o_rvalid0, 1'b1);
    check_data("rel_rdata", ba.o_rdata, 64'd0);
    step();

    // ---- single-master write then read of the same address ----
    drive0(1'b1, 1'b1, 6'd5, BEEF);
    #1;
    check("wr_gnt0", ba.o_gnt0, 1'b1);
    step();
    check("wr_wen", ba.o_sram_wen, 1'b1);
    check("wr_oen", ba.o_sram_oen, 1'b0);
    check_data("wr_addr", 64'(ba.o_sram_addr), 64'd5);
    check_data("wr_sdata", ba.o_sram_data, BEEF);
    drive0(1'b1, 1'b0, 6'd5, 64'd0);
    #1;
    check("rd_gnt0", ba.o_gnt0, 1'b1);
    step();
    check("rd_oen", ba.o_sram_oen, 1'b1);
    check("rd_wen", ba.o_sram_wen, 1'b0);
    check_data("rd_addr", 64'(ba.o_sram_addr), 64'd5);
    drive0(1'b0, 1'b0, 6'd0, 64'd0);
    step();
    check("idle_wen", ba.o_sram_wen, 1'b0);
    check("idle_oen", ba.o_sram_oen, 1'b0);
    check_data("idle_addr_hold", 64'(ba.o_sram_addr), 64'd5);
    check("rd_early_rvalid0", ba.o_rvalid0, 1'b0);
    step();
    check("rd_rvalid0", ba.o_rvalid0, 1'b1);
    check("rd_rvalid1", ba.o_rvalid1, 1'b0);
    check_data("rd_rdata", ba.o_rdata, BEEF);
    step();
    check("rd_pulse_end", ba.o_rvalid0, 1'b0);
    check_data("rd_rdata_hold", ba.o_rdata, BEEF);

    // ---- lone master 1, 16 back-to-back reads of 48..63 ----
    for (int t = 0; t < 20; t++) begin
      if (t < 16) drive1(1'b1, 1'b0, 6'(48 + t), 64'd0);
      else        drive1(1'b0, 1'b0, 6'd0, 64'd0);
      #1;
      check("lone_gnt1", ba.o_gnt1, t < 16);
      check("lone_gnt0", ba.o_gnt0, 1'b0);
      check("lone_rvalid1", ba.o_rvalid1, t >= 3 && t < 19);
      check("lone_rvalid0", ba.o_rvalid0, 1'b0);
      if (t >= 3 && t < 19) check_data("lone_rdata", ba.o_rdata, 64'(45 + t));
      step();
    end

    // ---- contention: m0 reads 0..3, m1 reads 32..35 ----
    i0 = 0;
    i1 = 0;
    for (int t = 0; t < 12; t++) begin
      drive0(i0 < 4, 1'b0, 6'(i0), 64'd0);
      drive1(i1 < 4, 1'b0, 6'(32 + i1), 64'd0);
      #1;
      check("cont_gnt0", ba.o_gnt0, t < 8 && (t % 2) == 0);
      check("cont_gnt1", ba.o_gnt1, t < 8 && (t % 2) == 1);
      if (ba.o_gnt0) i0++;
      if (ba.o_gnt1) i1++;
      d = t - 3;
      check("cont_rvalid0", ba.o_rvalid0, t >= 3 && t < 11 && (d % 2) == 0);
      check("cont_rvalid1", ba.o_rvalid1, t >= 3 && t < 11 && (d % 2) == 1);
      if (t >= 3 && t < 11)
        check_data("cont_rdata", ba.o_rdata, ((d % 2) == 0) ? 64'(d / 2) : 64'(32 + d / 2));
      step();
    end
    drive0(1'b0, 1'b0, 6'd0, 64'd0);
    drive1(1'b0, 1'b0, 6'd0, 64'd0);
    step();

    // ---- mid-flight reset ----
    drive0(1'b1, 1'b0, 6'd1, 64'd0);
    #1;
    check("mf_gnt_a1", ba.o_gnt0, 1'b1);
    step();
    drive0(1'b1, 1'b0, 6'd2, 64'd0);
    #1;
    check("mf_gnt_a2", ba.o_gnt0, 1'b1);
    step();
    rst = 1'b1;
    drive0(1'b1, 1'b0, 6'd3, 64'd0);
    #1;
    check("mf_gnt_in_rst", ba.o_gnt0, 1'b0);
    check("mf_rvalid_c2", ba.o_rvalid0, 1'b0);
    step();
    rst = 1'b0;
    drive0(1'b1, 1'b0, 6'd7, 64'd0);
    #1;
    check("mf_gnt_after", ba.o_gnt0, 1'b1);
    check("mf_oen_cleared", ba.o_sram_oen, 1'b0);
    check("mf_rvalid_c3", ba.o_rvalid0, 1'b0);
    step();
    drive0(1'b0, 1'b0, 6'd0, 64'd0);
    check("mf_rvalid_c4", ba.o_rvalid0, 1'b0);
    step();
    check("mf_rvalid_c5", ba.o_rvalid0, 1'b0);
    step();
    check("mf_rvalid_new", ba.o_rvalid0, 1'b1);
    check_data("mf_rdata_new", ba.o_rdata, 64'd7);
    step();
    check("mf_pulse_end", ba.o_rvalid0, 1'b0);

    // ---- RD_LAT=3 instance: single read of addr 9 ----
    bb.i_req0  = 1'b1;
    bb.i_addr0 = 6'd9;
    #1;
    check("lat3_gnt0", bb.o_gnt0, 1'b1);
    step();
    bb.i_req0 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      check("lat3_rvalid0", bb.o_rvalid0, k == 5);
      check("lat3_rvalid1", bb.o_rvalid1, 1'b0);
      if (k == 5) check_data("lat3_rdata", bb.o_rdata, 64'd9);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the 64-bit x 64-word banked SRAM (sram_extension).
- Accepts read and write requests from two independent masters, issues at most one SRAM access per cycle, and routes read data back to the originating master with a fixed latency.
- Sits between the SRAM macro wrapper and the datapath masters; the SRAM bank decode stays inside the SRAM block.

Parameters:
- BW_DATA, 64, data width, equal to the SRAM word width
- BW_ADDR, 6, word address width, 64 words
- RD_LAT, 1, SRAM read latency in cycles from the cycle oen is driven to valid i_sram_data; legal range 1..4

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  synchronous reset, active-high
- i_req0  in  1  master 0 request valid
- i_we0  in  1  master 0 write (1) / read (0)
- i_addr0  in  BW_ADDR  master 0 word address
- i_wdata0  in  BW_DATA  master 0 write data
- o_gnt0  out  1  master 0 request accepted this cycle (combinational)
- o_rvalid0  out  1  master 0 read data valid, 1-cycle pulse
- i_req1 / i_we1 / i_addr1 / i_wdata1 / o_gnt1 / o_rvalid1: same as master 0
- o_rdata  out  BW_DATA  read data, shared by both masters, qualified by o_rvalid0/1
- o_sram_addr  out  BW_ADDR  SRAM address
- o_sram_data  out  BW_DATA  SRAM write data
- o_sram_wen  out  1  SRAM write enable, active-high
- o_sram_oen  out  1  SRAM read/output enable, active-high
- i_sram_data  in  BW_DATA  SRAM read data

Behaviour:
- Reset, synchronous with i_rst=1 at a clock edge:
  - o_sram_wen, o_sram_oen, o_rvalid0 and o_rvalid1 are 0.
  - o_sram_addr, o_sram_data and o_rdata are 0.
  - Priority pointer is reset to master 0.
  - All in-flight read tags are cleared, so no o_rvalid fires for reads issued before reset.
  - o_gnt0 and o_gnt1 are forced to 0 while i_rst=1.
- Handshake:
  - A master holds i_req with stable we, addr and wdata until it sees gnt=1.
  - A transfer occurs in the cycle where req=1 and gnt=1.
  - A master may present a new request in the cycle after its grant.
- Arbitration, combinational:
  - Only one requesting master: it is granted.
  - Both requesting: the master named by the priority pointer is granted.
  - At most one gnt is high per cycle. The arbiter never stalls: if any req is high, one gnt is high.
- Priority pointer: after any grant it points to the other master. If there is no grant, it holds.
  - Result: a lone master is granted every cycle, back-to-back.
  - Result: two continuously requesting masters alternate 0,1,0,1.
- Issue stage, registered:
  - A grant in cycle N drives o_sram_addr, o_sram_data, o_sram_wen=we and o_sram_oen=~we in cycle N+1.
  - With no grant, wen=0 and oen=0 in the next cycle; addr and data hold their last value.
- Read return:
  - A tag (valid, master id) travels through a shift pipeline of depth RD_LAT.
  - i_sram_data is registered into o_rdata in the cycle the tag emerges.
  - The matching o_rvalid pulses in cycle N+2+RD_LAT (N+3 for default RD_LAT=1), for exactly one cycle.
  - o_rdata holds its value until the next read return.
- Writes produce no response.
- Ordering: SRAM accesses occur in grant order. A read granted after a write to the same address returns the new data.
- Throughput: one access per cycle sustained, with multiple reads in flight. There is no response backpressure; masters must always sink o_rvalid.
- Reset mid-operation: any request granted in the cycle reset asserts is dropped, and pending reads never return.

Test Plan:
- Reset: assert i_rst for 2 cycles with both masters requesting -> o_gnt0=o_gnt1=0 and all SRAM enables 0; in the first cycle after release, master 0 is granted.
- Write/read single master: m0 writes 0xDEAD_BEEF_0123_4567 to addr 5 (cycle N) -> wen=1, addr=5 in N+1. m0 then reads addr 5 at N+1 -> o_rvalid0=1, o_rdata=0xDEAD_BEEF_0123_4567 at N+4, o_rvalid1 stays 0.
- Contention: both masters issue continuous reads (m0 addr 0..3, m1 addr 32..35, preloaded with the address value as data) -> grants alternate 0,1,0,1; responses alternate o_rvalid0/o_rvalid1 with data 0,32,1,33,... with no gaps.
- Back-to-back lone master: m1 reads 16 consecutive addresses 48..63 -> gnt1 is high 16 consecutive cycles and 16 consecutive o_rvalid1 pulses carry in-order data.
- Mid-flight reset: m0 issues reads to addrs 1 and 2, then i_rst is asserted 1 cycle after the second grant -> no o_rvalid0 pulse after reset; the next read after reset returns correctly at N+3.
- RD_LAT=3 build: a single read granted at N -> o_rvalid at N+5 with the correct data.
